// File: rtl/gol_pkg.sv
// Shared types and default grid dimensions for the Game of Life display path.
// Optional feature macro used by the scanner: GOL_SCAN_POPCOUNT_EN.
package gol_pkg;

   typedef enum logic {
      SCAN_IDLE = 1'b0,
      SCAN_SEND = 1'b1
   } scan_state_t;

   localparam int GOL_ROWS = 8;
   localparam int GOL_COLS = 8;

endpackage

// File: rtl/gol_popcount.sv
// Combinational population count of a W-bit vector.
// Only instantiated when GOL_SCAN_POPCOUNT_EN is defined.
module gol_popcount #(
   parameter int W = 64
) (
   input  logic [W-1:0]           bits_i,
   output logic [$clog2(W+1)-1:0] count_o
);

   localparam int CW = $clog2(W + 1);

   always_comb begin
      count_o = '0;
      for (int i = 0; i < W; i++) begin
         count_o = count_o + {{(CW - 1){1'b0}}, bits_i[i]};
      end
   end

endmodule

// File: rtl/gol_grid_scanner.sv
// Snapshots a flattened Game of Life grid and streams it one row per valid/ready beat.
// Define GOL_SCAN_POPCOUNT_EN to report the live-cell count of each captured frame.
module gol_grid_scanner
   import gol_pkg::*;
#(
   parameter int ROWS      = GOL_ROWS,
   parameter int COLS      = GOL_COLS,
   parameter int SKIP_SAME = 1
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic [ROWS*COLS-1:0]            grid_in,
   input  logic                            grid_valid,
   output logic [COLS-1:0]                 row_data,
   output logic [$clog2(ROWS)-1:0]         row_idx,
   output logic                            row_valid,
   input  logic                            row_ready,
   output logic                            busy,
   output logic                            frame_done,
   output logic [7:0]                      drop_cnt,
   output logic [$clog2(ROWS*COLS+1)-1:0]  live_count
);

   localparam int N  = ROWS * COLS;
   localparam int IW = $clog2(ROWS);
   localparam int CW = $clog2(N + 1);

   scan_state_t     state_q, state_d;
   logic [N-1:0]    snap_q, snap_d;
   logic [N-1:0]    lastGrid_q, lastGrid_d;
   logic [IW-1:0]   rowIdx_q, rowIdx_d;
   logic [7:0]      dropCnt_q, dropCnt_d;
   logic            frameDone_q, frameDone_d;
   logic            capture;
   logic            beat;
   logic [COLS-1:0] rowsOf [ROWS];

   // A repeat of the last captured grid is not worth a new frame when SKIP_SAME is set.
   assign capture = (state_q == SCAN_IDLE) && grid_valid
                    && ((SKIP_SAME == 0) || (grid_in != lastGrid_q));
   assign beat    = (state_q == SCAN_SEND) && row_ready;

   always_comb begin
      state_d     = state_q;
      snap_d      = snap_q;
      lastGrid_d  = lastGrid_q;
      rowIdx_d    = rowIdx_q;
      dropCnt_d   = dropCnt_q;
      frameDone_d = 1'b0;
      case (state_q)
         SCAN_IDLE: begin
            if (capture) begin
               snap_d     = grid_in;
               lastGrid_d = grid_in;
               rowIdx_d   = '0;
               state_d    = SCAN_SEND;
            end
         end
         SCAN_SEND: begin
            if (grid_valid && (dropCnt_q != 8'hFF)) begin
               dropCnt_d = dropCnt_q + 8'd1;
            end
            if (beat) begin
               if (rowIdx_q == IW'(ROWS - 1)) begin
                  state_d     = SCAN_IDLE;
                  rowIdx_d    = '0;
                  frameDone_d = 1'b1;
               end else begin
                  rowIdx_d = rowIdx_q + IW'(1);
               end
            end
         end
         default: state_d = SCAN_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= SCAN_IDLE;
         snap_q      <= '0;
         lastGrid_q  <= '0;
         rowIdx_q    <= '0;
         dropCnt_q   <= '0;
         frameDone_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         snap_q      <= snap_d;
         lastGrid_q  <= lastGrid_d;
         rowIdx_q    <= rowIdx_d;
         dropCnt_q   <= dropCnt_d;
         frameDone_q <= frameDone_d;
      end
   end

   // Row 0 sits in the most significant slice of the flattened grid.
   always_comb begin
      for (int r = 0; r < ROWS; r++) begin
         rowsOf[r] = snap_q[(ROWS - 1 - r) * COLS +: COLS];
      end
   end

   assign busy       = (state_q == SCAN_SEND);
   assign row_valid  = busy;
   assign row_idx    = rowIdx_q;
   assign row_data   = busy ? rowsOf[rowIdx_q] : '0;
   assign frame_done = frameDone_q;
   assign drop_cnt   = dropCnt_q;

`ifdef GOL_SCAN_POPCOUNT_EN
   logic [CW-1:0] gridPop;
   logic [CW-1:0] liveCount_q;

   gol_popcount #(.W(N)) u_popcount (
      .bits_i  (grid_in),
      .count_o (gridPop)
   );

   // Counted from grid_in at capture time, which is exactly what lands in the snapshot.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         liveCount_q <= '0;
      end else if (capture) begin
         liveCount_q <= gridPop;
      end
   end

   assign live_count = liveCount_q;
`else
   assign live_count = '0;
`endif

endmodule

// File: tb/tb_gol_grid_scanner.sv
// Self-checking bench for gol_grid_scanner: directed scenarios plus randomized frames
// compared against a row/popcount/drop model derived from the grid arithmetic.
module tb_gol_grid_scanner;

   localparam int ROWS = 8;
   localparam int COLS = 8;
   localparam int N    = ROWS * COLS;
   localparam logic [N-1:0] GLIDER = 64'h0020_1070_0000_0000;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic [N-1:0]    grid_in = '0;
   logic            grid_valid = 1'b0;
   logic            row_ready = 1'b0;
   logic [COLS-1:0] row_data;
   logic [2:0]      row_idx;
   logic            row_valid;
   logic            busy;
   logic            frame_done;
   logic [7:0]      drop_cnt;
   logic [6:0]      live_count;

   int errors = 0;
   int checks = 0;

   gol_grid_scanner dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .grid_in    (grid_in),
      .grid_valid (grid_valid),
      .row_data   (row_data),
      .row_idx    (row_idx),
      .row_valid  (row_valid),
      .row_ready  (row_ready),
      .busy       (busy),
      .frame_done (frame_done),
      .drop_cnt   (drop_cnt),
      .live_count (live_count)
   );

   always #5 clk = ~clk;

   // Row r of a grid is the r-th byte counting down from the top of the vector.
   function automatic logic [COLS-1:0] model_row(input logic [N-1:0] g, input int r);
      return COLS'(g >> ((ROWS - 1 - r) * COLS));
   endfunction

   function automatic int model_live(input logic [N-1:0] g);
      int n = 0;
`ifdef GOL_SCAN_POPCOUNT_EN
      for (int i = 0; i < N; i++) if (g[i]) n++;
`endif
      return n;
   endfunction

   task automatic applyStimulus_reset();
      reset_n    = 1'b0;
      grid_valid = 1'b0;
      row_ready  = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      applyStimulus_reset();
      grid_in    = GLIDER;
      grid_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      grid_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({row_valid, frame_done, row_idx, row_data, live_count} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %h expected 0",
                  {row_valid, frame_done, row_idx, row_data, live_count});
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_busy: got %b expected 0", busy);
      end
      checks++;
      if (drop_cnt !== 8'd0) begin
         errors++;
         $display("[TB] FAIL reset_drop_cnt: got %0d expected 0", drop_cnt);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_glider();
      int beats = 0;
      int cyc = 0;
      applyStimulus_reset();
      grid_in    = GLIDER;
      grid_valid = 1'b1;
      row_ready  = 1'b1;
      @(negedge clk);
      grid_valid = 1'b0;
      checks++;
      if (row_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL glider_latency: row_valid got %b expected 1", row_valid);
      end
      checks++;
      if (live_count !== 7'(model_live(GLIDER))) begin
         errors++;
         $display("[TB] FAIL glider_live: got %0d expected %0d", live_count, model_live(GLIDER));
      end
      while (beats < ROWS && cyc < 40) begin
         if (row_valid) begin
            checks++;
            if (row_idx !== 3'(beats) || row_data !== model_row(GLIDER, beats)) begin
               errors++;
               $display("[TB] FAIL glider_row: got idx %0d data %h expected idx %0d data %h",
                        row_idx, row_data, beats, model_row(GLIDER, beats));
            end
            beats++;
         end
         cyc++;
         @(negedge clk);
      end
      checks++;
      if (beats != ROWS) begin
         errors++;
         $display("[TB] FAIL glider_beats: got %0d expected %0d", beats, ROWS);
      end
      checks++;
      if (frame_done !== 1'b1 || row_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL glider_done: got done %b valid %b expected 1 0", frame_done, row_valid);
      end
      @(negedge clk);
      checks++;
      if (frame_done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL glider_done_width: got %b expected 0", frame_done);
      end
   endtask

   task automatic test_backpressure();
      logic [N-1:0] g;
      int beats = 0;
      int cyc = 0;
      applyStimulus_reset();
      g          = {$urandom, $urandom} | 64'h1;
      grid_in    = g;
      grid_valid = 1'b1;
      @(negedge clk);
      grid_valid = 1'b0;
      while (beats < ROWS && cyc < 40) begin
         checks++;
         if (row_valid !== 1'b1 || row_idx !== 3'(beats) || row_data !== model_row(g, beats)) begin
            errors++;
            $display("[TB] FAIL bp_row: got v %b idx %0d data %h expected v 1 idx %0d data %h",
                     row_valid, row_idx, row_data, beats, model_row(g, beats));
         end
         row_ready = cyc[0];
         grid_in   = {$urandom, $urandom};
         if (row_ready) beats++;
         cyc++;
         @(negedge clk);
      end
      row_ready = 1'b0;
      checks++;
      if (cyc != 2 * ROWS) begin
         errors++;
         $display("[TB] FAIL bp_cycles: got %0d expected %0d", cyc, 2 * ROWS);
      end
      checks++;
      if (frame_done !== 1'b1) begin
         errors++;
         $display("[TB] FAIL bp_done: got %b expected 1", frame_done);
      end
   endtask

   task automatic test_drop();
      logic [N-1:0] g;
      int cyc = 0;
      applyStimulus_reset();
      g          = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
      grid_in    = g;
      grid_valid = 1'b1;
      @(negedge clk);
      grid_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         grid_valid = 1'b1;
         grid_in    = {$urandom, $urandom};
         @(negedge clk);
         grid_valid = 1'b0;
         @(negedge clk);
      end
      checks++;
      if (drop_cnt !== 8'd3) begin
         errors++;
         $display("[TB] FAIL drop_three: got %0d expected 3", drop_cnt);
      end
      for (int k = 0; k < 300; k++) begin
         grid_valid = 1'b1;
         grid_in    = {$urandom, $urandom};
         @(negedge clk);
         grid_valid = 1'b0;
         @(negedge clk);
      end
      checks++;
      if (drop_cnt !== 8'd255) begin
         errors++;
         $display("[TB] FAIL drop_saturate: got %0d expected 255", drop_cnt);
      end
      checks++;
      if (row_data !== model_row(g, 0)) begin
         errors++;
         $display("[TB] FAIL drop_snapshot: got %h expected %h", row_data, model_row(g, 0));
      end
      row_ready = 1'b1;
      while (busy && cyc < 20) begin
         cyc++;
         @(negedge clk);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL drop_drain: busy got %b expected 0", busy);
      end
   endtask

   task automatic test_skip_same();
      logic [N-1:0] gs [3];
      int expFrames [3] = '{1, 0, 1};
      int frames;
      applyStimulus_reset();
      gs[0] = {$urandom, $urandom} | 64'h1;
      gs[1] = gs[0];
      gs[2] = gs[0] ^ 64'h0000_0100_0000_0000;
      row_ready = 1'b1;
      for (int p = 0; p < 3; p++) begin
         frames     = 0;
         grid_in    = gs[p];
         grid_valid = 1'b1;
         @(negedge clk);
         grid_valid = 1'b0;
         for (int c = 0; c < 12; c++) begin
            if (frame_done) frames++;
            @(negedge clk);
         end
         checks++;
         if (frames != expFrames[p]) begin
            errors++;
            $display("[TB] FAIL skip_same_phase%0d: got %0d frames expected %0d", p, frames, expFrames[p]);
         end
      end
      checks++;
      if (drop_cnt !== 8'd0) begin
         errors++;
         $display("[TB] FAIL skip_same_drop: got %0d expected 0", drop_cnt);
      end
   endtask

   task automatic test_reset_midframe();
      logic [N-1:0] h;
      int cyc = 0;
      applyStimulus_reset();
      grid_in    = GLIDER;
      grid_valid = 1'b1;
      row_ready  = 1'b1;
      @(negedge clk);
      grid_valid = 1'b0;
      while (row_idx !== 3'd4 && cyc < 20) begin
         cyc++;
         @(negedge clk);
      end
      checks++;
      if (row_idx !== 3'd4) begin
         errors++;
         $display("[TB] FAIL midreset_reach_beat4: got idx %0d expected 4", row_idx);
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (row_valid !== 1'b0 || busy !== 1'b0 || row_idx !== 3'd0) begin
         errors++;
         $display("[TB] FAIL midreset_abort: got v %b busy %b idx %0d expected 0 0 0", row_valid, busy, row_idx);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (row_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midreset_no_resume: got %b expected 0", row_valid);
      end
      h          = {$urandom, $urandom} | 64'h1;
      grid_in    = h;
      grid_valid = 1'b1;
      @(negedge clk);
      grid_valid = 1'b0;
      checks++;
      if (row_valid !== 1'b1 || row_idx !== 3'd0 || row_data !== model_row(h, 0)) begin
         errors++;
         $display("[TB] FAIL midreset_restart: got v %b idx %0d data %h expected 1 0 %h",
                  row_valid, row_idx, row_data, model_row(h, 0));
      end
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] a, b;
      int cyc = 0;
      int doneAt = -1;
      applyStimulus_reset();
      a          = {$urandom, $urandom} | 64'h1;
      b          = ~a;
      row_ready  = 1'b1;
      grid_in    = a;
      grid_valid = 1'b1;
      @(negedge clk);
      grid_valid = 1'b0;
      while (doneAt < 0 && cyc < 20) begin
         if (frame_done) begin
            doneAt     = cyc;
            grid_in    = b;
            grid_valid = 1'b1;
         end
         cyc++;
         @(negedge clk);
      end
      grid_valid = 1'b0;
      checks++;
      if (doneAt != ROWS) begin
         errors++;
         $display("[TB] FAIL b2b_period: got frame_done at %0d expected %0d", doneAt, ROWS);
      end
      checks++;
      if (row_valid !== 1'b1 || row_idx !== 3'd0 || row_data !== model_row(b, 0)) begin
         errors++;
         $display("[TB] FAIL b2b_second_frame: got v %b idx %0d data %h expected 1 0 %h",
                  row_valid, row_idx, row_data, model_row(b, 0));
      end
      checks++;
      if (live_count !== 7'(model_live(b))) begin
         errors++;
         $display("[TB] FAIL b2b_live: got %0d expected %0d", live_count, model_live(b));
      end
      repeat (ROWS + 1) @(negedge clk);
   endtask

   task automatic test_random();
      logic [N-1:0] g;
      logic [N-1:0] lastGrid = '0;
      int expDrops = 0;
      int beats;
      int cyc;
      applyStimulus_reset();
      for (int f = 0; f < 6; f++) begin
         g = (f == 5) ? '1 : {$urandom, $urandom};
         while (g == lastGrid) g = {$urandom, $urandom};
         lastGrid   = g;
         grid_in    = g;
         grid_valid = 1'b1;
         @(negedge clk);
         grid_valid = 1'b0;
         beats = 0;
         cyc   = 0;
         while (beats < ROWS && cyc < 200) begin
            checks++;
            if (row_valid !== 1'b1 || row_idx !== 3'(beats) || row_data !== model_row(g, beats)
                || live_count !== 7'(model_live(g))) begin
               errors++;
               $display("[TB] FAIL random_row: got v %b idx %0d data %h live %0d expected 1 %0d %h %0d",
                        row_valid, row_idx, row_data, live_count, beats, model_row(g, beats), model_live(g));
            end
            row_ready  = ($urandom % 2) == 0;
            grid_valid = ($urandom % 4) == 0;
            grid_in    = {$urandom, $urandom};
            if (grid_valid && expDrops < 255) expDrops++;
            if (row_ready) beats++;
            cyc++;
            @(negedge clk);
         end
         grid_valid = 1'b0;
         row_ready  = 1'b0;
         checks++;
         if (frame_done !== 1'b1 || drop_cnt !== 8'(expDrops)) begin
            errors++;
            $display("[TB] FAIL random_frame_end: got done %b drops %0d expected 1 %0d",
                     frame_done, drop_cnt, expDrops);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_glider();
      test_backpressure();
      test_drop();
      test_skip_same();
      test_reset_midframe();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
